// File: rtl/cat_trap_game_ctrl.sv
// Cat Trap game controller: seeds random blocks, runs cursor/select play, moves the cat
// one step per placement and holds the win/lose screen before restarting.
module cat_trap_game_ctrl #(
   parameter int          GRID_W      = 11,
   parameter int          GRID_H      = 11,
   parameter int          INIT_BLOCKS = 8,
   parameter int          END_HOLD    = 100000000,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   localparam int         XW          = $clog2(GRID_W),
   localparam int         YW          = $clog2(GRID_H)
) (
   input  logic                     ClkPort,
   input  logic                     Resetn,
   input  logic                     BtnC,
   input  logic                     BtnU,
   input  logic                     BtnD,
   input  logic                     BtnL,
   input  logic                     BtnR,
   output logic [2:0]               state_o,
   output logic [XW-1:0]            cursor_x,
   output logic [YW-1:0]            cursor_y,
   output logic [XW-1:0]            cat_x,
   output logic [YW-1:0]            cat_y,
   output logic [GRID_W*GRID_H-1:0] grid_blocked,
   output logic [15:0]              move_count,
   output logic                     seed_done,
   output logic                     win_pulse,
   output logic                     lose_pulse
);
   localparam int CELLS = GRID_W * GRID_H;
   localparam int CW    = $clog2(CELLS);
   localparam int SCW   = CW + 1;
   localparam int TW    = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;
   localparam logic [XW-1:0] CAT_X0 = XW'(GRID_W / 2);
   localparam logic [YW-1:0] CAT_Y0 = YW'(GRID_H / 2);
   localparam logic [XW-1:0] X_MAX  = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MAX  = YW'(GRID_H - 1);

   typedef enum logic [2:0] {
      ST_START    = 3'd0,
      ST_PLAY     = 3'd1,
      ST_CAT_MOVE = 3'd2,
      ST_GAMEOVER = 3'd3,
      ST_GAMEWIN  = 3'd4
   } state_t;

   state_t           state_r;
   logic [15:0]      lfsr_r;
   logic [CELLS-1:0] grid_r;
   logic [XW-1:0]    cat_x_r, cursor_x_r;
   logic [YW-1:0]    cat_y_r, cursor_y_r;
   logic [15:0]      move_count_r;
   logic             seed_done_r, win_r, lose_r;
   logic [TW-1:0]    hold_r;
   logic [SCW-1:0]   seed_cnt_r;
   logic [4:0]       btn_prev_r;

   function automatic logic [CW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return CW'(int'(y) * GRID_W + int'(x));
   endfunction

   logic [4:0]    btn_now_s, btn_edge_s;
   logic [15:0]   lfsr_next_s;
   logic [CW-1:0] cand_s, cat_idx_s, cursor_idx_s;
   logic          cand_ok_s, cursor_ok_s;
   logic          up_free_s, right_free_s, down_free_s, left_free_s, trapped_s, on_border_s;
   logic [XW-1:0] next_x_s;
   logic [YW-1:0] next_y_s;

   assign btn_now_s    = {BtnC, BtnU, BtnD, BtnL, BtnR};
   assign btn_edge_s   = btn_now_s & ~btn_prev_r;
   assign lfsr_next_s  = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
   assign cand_s       = lfsr_r[CW-1:0];
   assign cat_idx_s    = cell_idx(cat_x_r, cat_y_r);
   assign cursor_idx_s = cell_idx(cursor_x_r, cursor_y_r);
   assign cand_ok_s    = (int'(cand_s) < CELLS) && (cand_s != cat_idx_s) && !grid_r[cand_s];
   assign cursor_ok_s  = !grid_r[cursor_idx_s] && (cursor_idx_s != cat_idx_s);

   // Cat step: first free neighbour in U, R, D, L order; none free means trapped.
   always_comb begin
      up_free_s    = (cat_y_r != YW'(0)) && !grid_r[cell_idx(cat_x_r, cat_y_r - YW'(1))];
      right_free_s = (cat_x_r != X_MAX) && !grid_r[cell_idx(cat_x_r + XW'(1), cat_y_r)];
      down_free_s  = (cat_y_r != Y_MAX) && !grid_r[cell_idx(cat_x_r, cat_y_r + YW'(1))];
      left_free_s  = (cat_x_r != XW'(0)) && !grid_r[cell_idx(cat_x_r - XW'(1), cat_y_r)];
      next_x_s     = cat_x_r;
      next_y_s     = cat_y_r;
      trapped_s    = 1'b0;
      if (up_free_s) begin
         next_y_s = cat_y_r - YW'(1);
      end else if (right_free_s) begin
         next_x_s = cat_x_r + XW'(1);
      end else if (down_free_s) begin
         next_y_s = cat_y_r + YW'(1);
      end else if (left_free_s) begin
         next_x_s = cat_x_r - XW'(1);
      end else begin
         trapped_s = 1'b1;
      end
      on_border_s = (next_x_s == XW'(0)) || (next_x_s == X_MAX) ||
                    (next_y_s == YW'(0)) || (next_y_s == Y_MAX);
   end

   // Game state machine and all board registers.
   always_ff @(posedge ClkPort or negedge Resetn) begin
      if (!Resetn) begin
         state_r      <= ST_START;
         lfsr_r       <= LFSR_SEED;
         grid_r       <= '0;
         cat_x_r      <= CAT_X0;
         cat_y_r      <= CAT_Y0;
         cursor_x_r   <= '0;
         cursor_y_r   <= '0;
         move_count_r <= 16'd0;
         seed_done_r  <= 1'b0;
         win_r        <= 1'b0;
         lose_r       <= 1'b0;
         hold_r       <= '0;
         seed_cnt_r   <= '0;
         btn_prev_r   <= 5'd0;
      end else begin
         lfsr_r     <= lfsr_next_s;
         btn_prev_r <= btn_now_s;
         win_r      <= 1'b0;
         lose_r     <= 1'b0;
         case (state_r)
            ST_START: begin
               if (seed_done_r) begin
                  if (btn_edge_s[4]) begin
                     state_r     <= ST_PLAY;
                     cursor_x_r  <= '0;
                     cursor_y_r  <= '0;
                     seed_done_r <= 1'b0;
                  end
               end else if (seed_cnt_r == SCW'(INIT_BLOCKS)) begin
                  seed_done_r <= 1'b1;
               end else if (cand_ok_s) begin
                  grid_r[cand_s] <= 1'b1;
                  seed_cnt_r     <= seed_cnt_r + SCW'(1);
               end
            end
            ST_PLAY: begin
               if (btn_edge_s[4]) begin
                  if (cursor_ok_s) begin
                     grid_r[cursor_idx_s] <= 1'b1;
                     if (move_count_r != 16'hFFFF) move_count_r <= move_count_r + 16'd1;
                     state_r <= ST_CAT_MOVE;
                  end
               end else if (btn_edge_s[3]) begin
                  if (cursor_y_r != YW'(0)) cursor_y_r <= cursor_y_r - YW'(1);
               end else if (btn_edge_s[2]) begin
                  if (cursor_y_r != Y_MAX) cursor_y_r <= cursor_y_r + YW'(1);
               end else if (btn_edge_s[1]) begin
                  if (cursor_x_r != XW'(0)) cursor_x_r <= cursor_x_r - XW'(1);
               end else if (btn_edge_s[0]) begin
                  if (cursor_x_r != X_MAX) cursor_x_r <= cursor_x_r + XW'(1);
               end
            end
            ST_CAT_MOVE: begin
               hold_r <= '0;
               if (trapped_s) begin
                  state_r <= ST_GAMEWIN;
                  win_r   <= 1'b1;
               end else begin
                  cat_x_r <= next_x_s;
                  cat_y_r <= next_y_s;
                  if (on_border_s) begin
                     state_r <= ST_GAMEOVER;
                     lose_r  <= 1'b1;
                  end else begin
                     state_r <= ST_PLAY;
                  end
               end
            end
            ST_GAMEOVER, ST_GAMEWIN: begin
               if (hold_r == TW'(END_HOLD - 1)) begin
                  state_r      <= ST_START;
                  hold_r       <= '0;
                  grid_r       <= '0;
                  cat_x_r      <= CAT_X0;
                  cat_y_r      <= CAT_Y0;
                  cursor_x_r   <= '0;
                  cursor_y_r   <= '0;
                  move_count_r <= 16'd0;
                  seed_done_r  <= 1'b0;
                  seed_cnt_r   <= '0;
               end else begin
                  hold_r <= hold_r + TW'(1);
               end
            end
            default: state_r <= ST_START;
         endcase
      end
   end

   assign state_o      = state_r;
   assign cursor_x     = cursor_x_r;
   assign cursor_y     = cursor_y_r;
   assign cat_x        = cat_x_r;
   assign cat_y        = cat_y_r;
   assign grid_blocked = grid_r;
   assign move_count   = move_count_r;
   assign seed_done    = seed_done_r;
   assign win_pulse    = win_r;
   assign lose_pulse   = lose_r;
endmodule

// File: tb/tb_cat_trap_game_ctrl.sv
// Scoreboard bench for cat_trap_game_ctrl: an 11x11 default instance and a 5x5 instance
// with no initial blocks and a short end hold.
module tb_cat_trap_game_ctrl;
   logic clk;
   logic rstn_a, rstn_b;
   logic [4:0] btn_a, btn_b;   // {C,U,D,L,R}

   logic [2:0]   state_a, state_b;
   logic [3:0]   cur_ax, cur_ay, cat_ax, cat_ay;
   logic [2:0]   cur_bx, cur_by, cat_bx, cat_by;
   logic [120:0] grid_a;
   logic [24:0]  grid_b;
   logic [15:0]  move_a, move_b;
   logic         seed_a, seed_b, win_a, win_b, lose_a, lose_b;

   localparam logic [4:0] B_C = 5'b10000, B_U = 5'b01000, B_D = 5'b00100,
                          B_L = 5'b00010, B_R = 5'b00001;

   cat_trap_game_ctrl dut_a (
      .ClkPort(clk), .Resetn(rstn_a),
      .BtnC(btn_a[4]), .BtnU(btn_a[3]), .BtnD(btn_a[2]), .BtnL(btn_a[1]), .BtnR(btn_a[0]),
      .state_o(state_a), .cursor_x(cur_ax), .cursor_y(cur_ay), .cat_x(cat_ax), .cat_y(cat_ay),
      .grid_blocked(grid_a), .move_count(move_a), .seed_done(seed_a),
      .win_pulse(win_a), .lose_pulse(lose_a));

   cat_trap_game_ctrl #(.GRID_W(5), .GRID_H(5), .INIT_BLOCKS(0), .END_HOLD(4)) dut_b (
      .ClkPort(clk), .Resetn(rstn_b),
      .BtnC(btn_b[4]), .BtnU(btn_b[3]), .BtnD(btn_b[2]), .BtnL(btn_b[1]), .BtnR(btn_b[0]),
      .state_o(state_b), .cursor_x(cur_bx), .cursor_y(cur_by), .cat_x(cat_bx), .cat_y(cat_by),
      .grid_blocked(grid_b), .move_count(move_b), .seed_done(seed_b),
      .win_pulse(win_b), .lose_pulse(lose_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string          name;
      int             sel;
      logic [127:0]   exp;
   } item_t;
   item_t q[$];

   int tests = 0;
   int fails = 0;
   int win_cnt = 0;
   int lose_cnt = 0;

   function automatic logic [127:0] get_val(input int sel);
      logic [127:0] v;
      v = '0;
      case (sel)
         0:  v = 128'(state_a);
         1:  v = 128'($countones(grid_a));
         2:  v = 128'(grid_a[60]);
         3:  v = 128'({cur_ax, cur_ay});
         4:  v = 128'({cat_ax, cat_ay});
         5:  v = 128'(move_a);
         6:  v = 128'(seed_a);
         7:  v = 128'(dut_a.lfsr_r);
         8:  v = 128'(grid_a);
         10: v = 128'(state_b);
         11: v = 128'({cat_bx, cat_by});
         12: v = 128'(grid_b);
         13: v = 128'(lose_cnt);
         14: v = 128'(win_cnt);
         15: v = 128'(move_b);
         16: v = 128'({cur_bx, cur_by});
         17: v = 128'(win_b);
         18: v = 128'(seed_b);
         19: v = 128'(lose_b);
         default: v = '0;
      endcase
      return v;
   endfunction

   task automatic chk(input string n, input int sel, input logic [127:0] v);
      item_t it;
      it.name = n;
      it.sel  = sel;
      it.exp  = v;
      q.push_back(it);
   endtask

   // Monitor: counts end pulses and compares every queued expectation away from the clock edge.
   always @(negedge clk) begin
      item_t it;
      logic [127:0] act;
      if (win_b)  win_cnt++;
      if (lose_b) lose_cnt++;
      while (q.size() > 0) begin
         it  = q.pop_front();
         act = get_val(it.sel);
         tests++;
         if (act !== it.exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", it.name, act, it.exp);
         end
      end
   end

   task automatic press_a(input logic [4:0] m);
      @(negedge clk); btn_a = m; @(posedge clk); #1;
   endtask
   task automatic rel_a();
      @(negedge clk); btn_a = 5'd0; @(posedge clk); #1;
   endtask
   task automatic tap_a(input logic [4:0] m);
      press_a(m); rel_a();
   endtask
   task automatic press_b(input logic [4:0] m);
      @(negedge clk); btn_b = m; @(posedge clk); #1;
   endtask
   task automatic rel_b();
      @(negedge clk); btn_b = 5'd0; @(posedge clk); #1;
   endtask
   task automatic tap_b(input logic [4:0] m);
      press_b(m); rel_b();
   endtask

   task automatic wait_seed_a();
      for (int i = 0; i < 1000; i++) begin
         if (seed_a) break;
         @(posedge clk); #1;
      end
      chk("seed_done_a", 6, 128'd1);
   endtask
   task automatic wait_seed_b();
      for (int i = 0; i < 100; i++) begin
         if (seed_b) break;
         @(posedge clk); #1;
      end
      chk("seed_done_b", 18, 128'd1);
   endtask
   task automatic wait_state_b(input logic [2:0] s, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (state_b == s) break;
         @(posedge clk); #1;
      end
      chk("wait_state_b", 10, 128'(s));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn_a = 1'b0; rstn_b = 1'b0; btn_a = 5'd0; btn_b = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state_a", 0, 128'd0);
      chk("rst_cat_a",   4, 128'h55);
      chk("rst_lfsr_a",  7, 128'hACE1);
      chk("rst_grid_a",  8, 128'd0);
      chk("rst_state_b", 10, 128'd0);
      chk("rst_cat_b",   11, 128'h12);
      @(negedge clk); rstn_a = 1'b1; rstn_b = 1'b1;

      // Seeding on the default board
      wait_seed_a();
      chk("seed_popcount", 1, 128'd8);
      chk("seed_cat_free", 2, 128'd0);

      // Cursor saturation and priority
      press_a(B_C);
      chk("play_entry_a", 0, 128'd1);
      chk("play_cursor_a", 3, 128'h00);
      rel_a();
      tap_a(B_U); tap_a(B_L);
      chk("cursor_top_left", 3, 128'h00);
      for (int i = 0; i < 12; i++) tap_a(B_R);
      chk("cursor_right_sat", 3, 128'hA0);
      tap_a(B_D); tap_a(B_L);
      chk("cursor_9_1", 3, 128'h91);
      press_a(B_U | B_R);
      chk("cursor_u_over_r", 3, 128'h90);
      rel_a();

      // Reset mid-PLAY
      @(negedge clk); rstn_a = 1'b0;
      @(posedge clk); #1;
      chk("midrst_state", 0, 128'd0);
      chk("midrst_grid",  8, 128'd0);
      chk("midrst_cat",   4, 128'h55);
      chk("midrst_moves", 5, 128'd0);
      chk("midrst_lfsr",  7, 128'hACE1);
      chk("midrst_cursor", 3, 128'h00);
      @(negedge clk); rstn_a = 1'b1;

      // 5x5: cat steps up, then escapes to the border
      wait_seed_b();
      press_b(B_C);
      chk("play_entry_b", 10, 128'd1);
      rel_b();
      press_b(B_C);
      chk("catmove_state", 10, 128'd2);
      chk("place_grid_1",  12, 128'h1);
      chk("place_moves_1", 15, 128'd1);
      rel_b();
      chk("after_move1_state", 10, 128'd1);
      chk("after_move1_cat",   11, 128'h11);
      tap_b(B_D);
      chk("cursor_b_0_1", 16, 128'h01);
      press_b(B_C);
      chk("place_grid_2",  12, 128'h21);
      chk("place_moves_2", 15, 128'd2);
      rel_b();
      chk("gameover_state", 10, 128'd3);
      chk("lose_pulse_hi",  19, 128'd1);
      chk("escape_cat",     11, 128'h10);
      @(posedge clk); #1;
      chk("lose_pulse_lo",  19, 128'd0);
      chk("gameover_held",  10, 128'd3);
      wait_state_b(3'd0, 20);
      chk("restart_grid",  12, 128'd0);
      chk("restart_moves", 15, 128'd0);
      chk("restart_cat",   11, 128'h12);
      chk("lose_count",    13, 128'd1);

      // 5x5: trap the cat
      wait_seed_b();
      tap_b(B_C);
      chk("play_entry_b2", 10, 128'd1);
      @(negedge clk);
      force dut_b.grid_r = 25'h0002880;
      #1 release dut_b.grid_r;
      chk("forced_grid", 12, 128'h2880);
      tap_b(B_D); tap_b(B_D); tap_b(B_D); tap_b(B_R); tap_b(B_R);
      chk("cursor_b_2_3", 16, 128'h13);
      press_b(B_C);
      chk("trap_catmove", 10, 128'd2);
      chk("trap_grid",    12, 128'h22880);
      rel_b();
      chk("gamewin_state", 10, 128'd4);
      chk("win_pulse_hi",  17, 128'd1);
      chk("trapped_cat",   11, 128'h12);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("gamewin_hold", 10, 128'd4);
      end
      chk("win_pulse_lo", 17, 128'd0);
      @(posedge clk); #1;
      chk("hold_expire_start", 10, 128'd0);
      chk("hold_expire_grid",  12, 128'd0);
      chk("win_count",         14, 128'd1);

      // Select on an already blocked cell is ignored
      wait_seed_b();
      tap_b(B_C);
      tap_b(B_C);
      chk("block_play_state", 10, 128'd1);
      chk("block_moves_1",    15, 128'd1);
      press_b(B_C);
      chk("blocked_sel_state", 10, 128'd1);
      chk("blocked_sel_moves", 15, 128'd1);
      chk("blocked_sel_grid",  12, 128'h1);
      rel_b();
      chk("blocked_sel_cat",   11, 128'h11);

      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL queue_drained actual=%0d expected=0", q.size());
      end
      if (tests < 12) begin
         fails++;
         $display("FAIL tests_executed actual=%0d expected>=12", tests);
      end
      if (state_b !== 3'd1) begin
         fails++;
         $display("FAIL final_state_b actual=%0h expected=1", state_b);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
